// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the up/down Gray counter and its users.
// Functions work on a fixed container width; callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int s = 1; s < GRAY_MAX_W; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_codec.sv
// Combinational Gray/binary converter; TO_GRAY selects the direction.
// Both directions are built bitwise so they stay width-generic.
module gray_codec #(
    parameter int WIDTH   = 4,
    parameter bit TO_GRAY = 1'b1
) (
    input  logic [WIDTH-1:0] src,
    output logic [WIDTH-1:0] dst
);

    assign dst[WIDTH-1] = src[WIDTH-1];

    generate
        if (TO_GRAY) begin : g_enc
            for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
                assign dst[i] = src[i+1] ^ src[i];
            end
        end else begin : g_dec
            // Reduction over the upper slice avoids a ripple chain through dst.
            for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
                assign dst[i] = ^src[WIDTH-1:i];
            end
        end
    endgenerate

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter with synchronous load and wrap/saturate terminal.
// The gray output comes straight from a flop so it is safe to synchronise.
module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter bit          WRAP    = 1'b1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RST_VAL)));

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrapped_r;
    logic [WIDTH-1:0] load_dec_s;
    logic [WIDTH-1:0] load_bin_s;
    logic [WIDTH-1:0] bin_nxt_s;
    logic [WIDTH-1:0] gray_nxt_s;
    logic             wrap_nxt_s;
    logic             tc_s;

    gray_codec #(.WIDTH(WIDTH), .TO_GRAY(1'b0)) u_load_dec (
        .src (load_val),
        .dst (load_dec_s)
    );

    gray_codec #(.WIDTH(WIDTH), .TO_GRAY(1'b1)) u_next_enc (
        .src (bin_nxt_s),
        .dst (gray_nxt_s)
    );

    assign load_bin_s = load_gray ? load_dec_s : load_val;
    assign tc_s       = up ? (bin_r == MAX) : (bin_r == ZERO);

    // Next binary count and wrap flag: load beats enable beats hold.
    always_comb begin
        bin_nxt_s  = bin_r;
        wrap_nxt_s = 1'b0;
        if (load) begin
            bin_nxt_s = load_bin_s;
        end else if (en) begin
            if (tc_s) begin
                if (WRAP) begin
                    bin_nxt_s  = up ? ZERO : MAX;
                    wrap_nxt_s = 1'b1;
                end else begin
                    bin_nxt_s = bin_r;
                end
            end else if (up) begin
                bin_nxt_s = bin_r + ONE;
            end else begin
                bin_nxt_s = bin_r - ONE;
            end
        end else begin
            bin_nxt_s = bin_r;
        end
    end

    // State registers; gray is registered from the encoded next value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r     <= RST_BIN;
            gray_r    <= RST_GRAY;
            wrapped_r <= 1'b0;
        end else begin
            bin_r     <= bin_nxt_s;
            gray_r    <= gray_nxt_s;
            wrapped_r <= wrap_nxt_s;
        end
    end

    assign bin     = bin_r;
    assign gray    = gray_r;
    assign wrapped = wrapped_r;
    assign tc      = tc_s;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed + random bench for gray_counter_ud with a scoreboard queue.
// Three instances: 4-bit wrap (reset 5), 4-bit saturate, 8-bit wrap (reset 0x3C).
module tb_gray_counter_ud;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, up, load, load_gray;
    logic [7:0] lv;
    logic [3:0] bin_a, gray_a, bin_b, gray_b;
    logic [7:0] bin_c, gray_c;
    logic       tc_a, tc_b, tc_c, wr_a, wr_b, wr_c;

    int total = 0;
    int bad   = 0;

    int wd[3] = '{4, 4, 8};
    bit wf[3] = '{1'b1, 1'b0, 1'b1};
    int rv[3] = '{5, 0, 60};
    logic [31:0] mb[3];
    logic        mw[3];

    typedef struct {
        int          k;
        logic [31:0] b;
        logic [31:0] g;
        logic        w;
    } exp_t;
    exp_t sb[$];

    gray_counter_ud #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(5)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .load_val(lv[3:0]), .gray(gray_a), .bin(bin_a), .tc(tc_a), .wrapped(wr_a));

    gray_counter_ud #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .load_val(lv[3:0]), .gray(gray_b), .bin(bin_b), .tc(tc_b), .wrapped(wr_b));

    gray_counter_ud #(.WIDTH(8), .WRAP(1'b1), .RST_VAL(60)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .load_val(lv), .gray(gray_c), .bin(bin_c), .tc(tc_c), .wrapped(wr_c));

    function automatic logic [31:0] m_b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] m_g2b(input logic [31:0] g);
        logic [31:0] b;
        b = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            b[i] = (i == 31) ? g[i] : (b[i+1] ^ g[i]);
        end
        return b;
    endfunction

    function automatic logic [31:0] get_bin(input int k);
        case (k)
            0: return {28'd0, bin_a};
            1: return {28'd0, bin_b};
            default: return {24'd0, bin_c};
        endcase
    endfunction

    function automatic logic [31:0] get_gray(input int k);
        case (k)
            0: return {28'd0, gray_a};
            1: return {28'd0, gray_b};
            default: return {24'd0, gray_c};
        endcase
    endfunction

    function automatic logic get_tc(input int k);
        case (k)
            0: return tc_a;
            1: return tc_b;
            default: return tc_c;
        endcase
    endfunction

    function automatic logic get_wr(input int k);
        case (k)
            0: return wr_a;
            1: return wr_b;
            default: return wr_c;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check tc, push expectations from the model, clock once, pop and compare.
    task automatic cycle();
        exp_t        e;
        logic [31:0] mx, nb;
        logic        nw, mtc;
        #1;
        for (int k = 0; k < 3; k++) begin
            mx  = (32'd1 << wd[k]) - 32'd1;
            mtc = up ? (mb[k] == mx) : (mb[k] == 32'd0);
            chk($sformatf("tc%0d", k), {31'd0, get_tc(k)}, {31'd0, mtc});
            nb = mb[k];
            nw = 1'b0;
            if (load) begin
                nb = {24'd0, lv} & mx;
                if (load_gray) nb = m_g2b(nb);
            end else if (en) begin
                if (up && mb[k] == mx) begin
                    if (wf[k]) begin nb = 32'd0; nw = 1'b1; end
                end else if (!up && mb[k] == 32'd0) begin
                    if (wf[k]) begin nb = mx; nw = 1'b1; end
                end else begin
                    nb = (up ? mb[k] + 32'd1 : mb[k] - 32'd1) & mx;
                end
            end
            mb[k] = nb;
            mw[k] = nw;
            e = '{k, nb, m_b2g(nb), nw};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("bin%0d", e.k), get_bin(e.k), e.b);
            chk($sformatf("gray%0d", e.k), get_gray(e.k), e.g);
            chk($sformatf("wrapped%0d", e.k), {31'd0, get_wr(e.k)}, {31'd0, e.w});
        end
    endtask

    task automatic drive(input logic l, input logic lg, input logic e, input logic u,
                         input logic [7:0] v);
        load = l; load_gray = lg; en = e; up = u; lv = v;
        cycle();
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 3; k++) begin
            mb[k] = rv[k];
            mw[k] = 1'b0;
            chk($sformatf("rst_bin%0d", k), get_bin(k), mb[k]);
            chk($sformatf("rst_gray%0d", k), get_gray(k), m_b2g(mb[k]));
            chk($sformatf("rst_wr%0d", k), {31'd0, get_wr(k)}, 32'd0);
        end
    endtask

    // Reset pulse between edges; outputs must change without a clock.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_reset_state();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] prev;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 1'b0; lv = 8'd0;
        #3;
        check_reset_state();
        chk("rst_gray_a_0111", {28'd0, gray_a}, 32'h7);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Up count through a full wrap.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 16; i++) begin
            prev = gray_a;
            drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
            chk("onebit_up", $countones(gray_a ^ prev), 32'd1);
        end
        chk("up_wrap_bin", {28'd0, bin_a}, 32'd0);
        chk("up_wrap_pulse", {31'd0, wr_a}, 32'd1);

        // Saturating instance sits at 15.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        chk("sat_hold", {28'd0, bin_b}, 32'd15);
        chk("sat_nowrap", {31'd0, wr_b}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("sat_down", {28'd0, bin_b}, 32'd14);

        // Gray load overrides enable.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h0C);
        chk("load_bin", {28'd0, bin_a}, 32'd8);
        chk("load_gray", {28'd0, gray_a}, 32'hC);

        // Down wrap from zero.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        prev = gray_a;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("down_bin", {28'd0, bin_a}, 32'd15);
        chk("down_gray", {28'd0, gray_a}, 32'h8);
        chk("down_pulse", {31'd0, wr_a}, 32'd1);
        chk("onebit_down", $countones(gray_a ^ prev), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("pulse_end", {31'd0, wr_a}, 32'd0);

        // Mid-count reset, then resume from the reset value.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd8);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        chk("at_nine", {28'd0, bin_a}, 32'd9);
        pulse_reset();
        chk("mid_rst_bin", {28'd0, bin_a}, 32'd5);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        chk("resume_bin", {28'd0, bin_a}, 32'd6);

        // Random traffic against the model, all widths.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 24) == 0) pulse_reset();
            drive(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
